store_merge_unit: RTL
=====================

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  store request present; req_ready  out  1  unit can accept a request.
REQ-004 SHALL have ports: req_addr  in  32  byte address; req_data  in  32  register value, stored from its low bits.
REQ-005 SHALL have ports: req_size  in  2  0=byte, 1=halfword, 2=word, 3=reserved.
REQ-006 SHALL have ports: mem_addr  out  32  word address with [1:0]=0; mem_rd  out  1  read strobe; mem_wr  out  1  write strobe.
REQ-007 SHALL have ports: mem_wdata  out  32  merged write word; mem_rdata  in  32  read word; mem_ack  in  1  access complete.
REQ-008 SHALL have ports: done  out  1  one-cycle completion pulse; fault  out  1  misalignment/reserved flag (STORE_ALIGN_CHECK_EN only).

Function
REQ-009 SHALL run FSM states IDLE, RD, WR, DONE; req_ready=1 only in IDLE.
REQ-010 SHALL accept a request when req_valid and req_ready are both 1, registering addr, data and size on that edge.
REQ-011 SHALL go from IDLE to RD for byte/halfword stores and to WR directly for word stores.
REQ-012 SHALL assert mem_rd throughout RD, capture mem_rdata on the edge where mem_ack=1, then enter WR.
REQ-013 SHALL assert mem_wr throughout WR with mem_wdata stable, enter DONE on mem_ack=1.
REQ-014 SHALL pulse done=1 for exactly the single DONE cycle, then return to IDLE.
REQ-015 SHALL hold mem_addr = {captured addr[31:2],2'b00} constant from acceptance until DONE.
REQ-016 SHALL merge little-endian: byte replaces bits [8k+7:8k] (k=addr[1:0]) with data[7:0]; halfword replaces [16h+15:16h] (h=addr[1]) with data[15:0]; other lanes keep the read word.
REQ-017 SHALL drive mem_wdata = captured data unmodified for word stores.
REQ-018 SHALL spend at least one cycle in RD and WR; mem_ack high in the first cycle is valid.
REQ-019 SHALL ignore mem_ack outside RD/WR; mem_rd and mem_wr SHALL never be high together.
REQ-020 SHALL give minimum latency, acceptance to done: word = 2 cycles, byte/halfword = 3 cycles.

Reset
REQ-021 SHALL on reset enter IDLE with req_ready=1, mem_rd=0, mem_wr=0, done=0, fault=0, mem_addr=0, mem_wdata=0.
REQ-022 SHALL on reset mid-operation abandon the store, drop strobes at that edge, and emit no done.

Configuration
REQ-023 SHALL with STORE_ALIGN_CHECK_EN defined flag a halfword with addr[0]=1, a word with addr[1:0]!=0, or req_size=3: no memory access, go directly to DONE with done=1 and fault=1 in the same cycle.
REQ-024 SHALL without STORE_ALIGN_CHECK_EN omit the fault port: halfword lane from addr[1] only, word ignores addr[1:0], req_size=3 is treated as word.

Verification
REQ-025 SHALL cover: byte store, addr=0x103, data=0x000000AB, rdata=0x11223344 -> mem_addr=0x100, mem_wdata=0xAB223344, done once.
REQ-026 SHALL cover: halfword store, addr=0x202, data=0xFFFFBEEF, rdata=0x11223344 -> mem_wdata=0xBEEF3344, no mem_rd in the word case.
REQ-027 SHALL cover: word store, addr=0x300, data=0xDEADBEEF, ack first cycle -> mem_rd never high, done 2 cycles after accept.
REQ-028 SHALL cover: mem_ack delayed 4 cycles in RD -> mem_rd held 5 cycles, mem_addr stable, req_ready=0 throughout.
REQ-029 SHALL cover: reset asserted while in WR -> next cycle IDLE, mem_wr=0, req_ready=1, no done.
REQ-030 SHALL cover: STORE_ALIGN_CHECK_EN, halfword at addr=0x101 -> no mem_rd/mem_wr, done=1 with fault=1 next cycle.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store merge unit: performs byte/halfword stores as a read-merge-write
// on a word-wide memory port; word stores go straight to the write.
// Ports: clk, reset (sync, active-high); req_valid/req_ready with
// req_addr, req_data, req_size (0=B, 1=H, 2=W, 3=rsvd); mem_addr,
// mem_rd, mem_wr, mem_wdata, mem_rdata, mem_ack; done pulse.
// Optional STORE_ALIGN_CHECK_EN adds the fault output: misaligned
// halfword/word or size 3 completes at once with done and fault.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done
`ifdef STORE_ALIGN_CHECK_EN
  ,
  output logic        fault
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        accept;
  logic        is_word;
  logic        bad;
  logic [1:0]  lane_q;
  logic        byte_q;
  logic [15:0] data_q;
  logic [31:0] merged;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state == IDLE);
  assign mem_rd    = (state == RD);
  assign mem_wr    = (state == WR);
  assign done      = (state == DONE);

`ifdef STORE_ALIGN_CHECK_EN
  logic fault_q;

  assign is_word = (req_size == 2'd2);
  assign bad     = (req_size == 2'd3)
                || (req_size == 2'd1 && req_addr[0])
                || (req_size == 2'd2 && req_addr[1:0] != 2'b00);
  assign fault   = done && fault_q;
`else
  // Size 3 falls into the word path; alignment bits are ignored.
  assign is_word = req_size[1];
  assign bad     = 1'b0;
`endif

  // Little-endian lane replacement over the word just read.
  always_comb begin
    merged = mem_rdata;
    if (byte_q)
      merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = data_q;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bad)
            state_nxt = DONE;
          else if (is_word)
            state_nxt = WR;
          else
            state_nxt = RD;
        end
      end
      RD:   if (mem_ack) state_nxt = WR;
      WR:   if (mem_ack) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      data_q    <= 16'h0;
      lane_q    <= 2'b00;
      byte_q    <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
      fault_q   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        mem_addr  <= {req_addr[31:2], 2'b00};
        // Word stores write the register value as-is; sub-word
        // stores overwrite this with the merged word in RD.
        mem_wdata <= req_data;
        data_q    <= req_data[15:0];
        lane_q    <= req_addr[1:0];
        byte_q    <= (req_size == 2'd0);
`ifdef STORE_ALIGN_CHECK_EN
        fault_q   <= bad;
`endif
      end
      if (state == RD && mem_ack)
        mem_wdata <= merged;
    end
  end

endmodule
